// File: rtl/hazard_pkg.sv
// Constants and the operand-source code shared by the hazard/forwarding unit.
package hazard_pkg;
    localparam logic [4:0] REG_X0        = 5'd0;
    localparam int         CNT_W_DEFAULT = 32;

    // Operand source as seen from ID, before mapping onto a specific mux enum
    typedef enum logic [1:0] {
        SRC_RF    = 2'b00,
        SRC_EX    = 2'b01,
        SRC_WB    = 2'b10,
        SRC_RDATA = 2'b11
    } fwd_src_t;
endpackage

// File: rtl/rv32i_mux_types.sv
// Shared datapath mux select encodings for the RV32I pipeline.
// The EX forward enums share one ordering so the two operand paths decode identically.
package forwardmux1;
    typedef enum logic [1:0] {
        idex_rs1   = 2'b00,
        exmem_alu  = 2'b01,
        regfilemux = 2'b10,
        mem_rdata  = 2'b11
    } forwardmux1_sel_t;
endpackage

package forwardmux2;
    typedef enum logic [1:0] {
        idex_rs2   = 2'b00,
        exmem_alu  = 2'b01,
        regfilemux = 2'b10,
        mem_rdata  = 2'b11
    } forwardmux2_sel_t;
endpackage

package mem_forwardmux2;
    typedef enum logic {
        exmem_rs2  = 1'b0,
        regfilemux = 1'b1
    } mem_forwardmux2_sel_t;
endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Pipeline <-> hazard/forwarding unit signal bundle.
interface hazard_fwd_unit_if #(
    parameter int CNT_W = hazard_pkg::CNT_W_DEFAULT
);
    logic       icache_req, icache_resp, dcache_req, dcache_resp;
    logic [4:0] ifid_rs1, ifid_rs2, idex_rs2, idex_rd, exmem_rd;
    logic       idex_regwrite, idex_is_load, exmem_regwrite;
    logic       br_taken, cnt_clr;

    logic       pc_load, ifid_load, idex_load, exmem_load, memwb_load;
    logic       ifid_flush, idex_flush;
    forwardmux1::forwardmux1_sel_t         fwd1_sel;
    forwardmux2::forwardmux2_sel_t         fwd2_sel;
    mem_forwardmux2::mem_forwardmux2_sel_t memfwd2_sel;
    logic [CNT_W-1:0] cnt_stall, cnt_bubble, cnt_flush;

    modport master (
        output icache_req, icache_resp, dcache_req, dcache_resp,
               ifid_rs1, ifid_rs2, idex_rs2, idex_rd, exmem_rd,
               idex_regwrite, idex_is_load, exmem_regwrite, br_taken, cnt_clr,
        input  pc_load, ifid_load, idex_load, exmem_load, memwb_load,
               ifid_flush, idex_flush, fwd1_sel, fwd2_sel, memfwd2_sel,
               cnt_stall, cnt_bubble, cnt_flush
    );

    modport slave (
        input  icache_req, icache_resp, dcache_req, dcache_resp,
               ifid_rs1, ifid_rs2, idex_rs2, idex_rd, exmem_rd,
               idex_regwrite, idex_is_load, exmem_regwrite, br_taken, cnt_clr,
        output pc_load, ifid_load, idex_load, exmem_load, memwb_load,
               ifid_flush, idex_flush, fwd1_sel, fwd2_sel, memfwd2_sel,
               cnt_stall, cnt_bubble, cnt_flush
    );
endinterface

// File: rtl/fwd_src_sel.sv
// Priority compare of one ID source index against the EX and MEM producers.
module fwd_src_sel
    import hazard_pkg::*;
#(
    parameter bit LOAD_USE_BUBBLE = 1'b1
) (
    input  logic [4:0] rs,
    input  logic [4:0] idex_rd,
    input  logic       idex_regwrite,
    input  logic       idex_is_load,
    input  logic [4:0] exmem_rd,
    input  logic       exmem_regwrite,
    output fwd_src_t   src
);
    // EX is the younger producer, so it shadows a MEM match on the same index
    always_comb begin
        src = SRC_RF;
        if (rs == REG_X0) begin
            src = SRC_RF;
        end else if (idex_regwrite && idex_rd == rs) begin
            if (idex_is_load && !LOAD_USE_BUBBLE) src = SRC_RDATA;
            else                                  src = SRC_EX;
        end else if (exmem_regwrite && exmem_rd == rs) begin
            src = SRC_WB;
        end
    end
endmodule

// File: rtl/hazard_fwd_unit.sv
// Pipeline stall/bubble/flush strobes plus ID-resolved, EX/MEM-registered forward selects.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter bit LOAD_USE_BUBBLE = 1'b1,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input logic              clk,
    input logic              rst,
    hazard_fwd_unit_if.slave bus
);
    logic mem_busy, load_use, flush_ev, bubble_ev;
    logic pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld, ifid_fl, idex_fl;

    assign mem_busy = (bus.icache_req & ~bus.icache_resp) | (bus.dcache_req & ~bus.dcache_resp);
    assign load_use = LOAD_USE_BUBBLE && bus.idex_is_load && bus.idex_regwrite &&
                      (bus.idex_rd != REG_X0) &&
                      ((bus.idex_rd == bus.ifid_rs1) || (bus.idex_rd == bus.ifid_rs2));
    assign flush_ev  = rst && !mem_busy && bus.br_taken;
    assign bubble_ev = rst && !mem_busy && !bus.br_taken && load_use;

    always_comb begin
        pc_ld    = 1'b0;
        ifid_ld  = 1'b0;
        idex_ld  = 1'b0;
        exmem_ld = 1'b0;
        memwb_ld = 1'b0;
        ifid_fl  = 1'b0;
        idex_fl  = 1'b0;
        if (rst && !mem_busy) begin
            pc_ld    = 1'b1;
            ifid_ld  = 1'b1;
            idex_ld  = 1'b1;
            exmem_ld = 1'b1;
            memwb_ld = 1'b1;
            if (bus.br_taken) begin
                ifid_fl = 1'b1;
                idex_fl = 1'b1;
            end else if (load_use) begin
                pc_ld   = 1'b0;
                ifid_ld = 1'b0;
                idex_fl = 1'b1;
            end
        end
    end

    assign bus.pc_load    = pc_ld;
    assign bus.ifid_load  = ifid_ld;
    assign bus.idex_load  = idex_ld;
    assign bus.exmem_load = exmem_ld;
    assign bus.memwb_load = memwb_ld;
    assign bus.ifid_flush = ifid_fl;
    assign bus.idex_flush = idex_fl;

    logic [1:0][4:0] rs_id;
    fwd_src_t        src_n [2];

    assign rs_id = {bus.ifid_rs2, bus.ifid_rs1};

    for (genvar i = 0; i < 2; i++) begin : g_src
        fwd_src_sel #(.LOAD_USE_BUBBLE(LOAD_USE_BUBBLE)) u_sel (
            .rs             (rs_id[i]),
            .idex_rd        (bus.idex_rd),
            .idex_regwrite  (bus.idex_regwrite),
            .idex_is_load   (bus.idex_is_load),
            .exmem_rd       (bus.exmem_rd),
            .exmem_regwrite (bus.exmem_regwrite),
            .src            (src_n[i])
        );
    end

    function automatic forwardmux1::forwardmux1_sel_t to_fwd1(input fwd_src_t s);
        case (s)
            SRC_EX:    return forwardmux1::exmem_alu;
            SRC_WB:    return forwardmux1::regfilemux;
            SRC_RDATA: return forwardmux1::mem_rdata;
            default:   return forwardmux1::idex_rs1;
        endcase
    endfunction

    function automatic forwardmux2::forwardmux2_sel_t to_fwd2(input fwd_src_t s);
        case (s)
            SRC_EX:    return forwardmux2::exmem_alu;
            SRC_WB:    return forwardmux2::regfilemux;
            SRC_RDATA: return forwardmux2::mem_rdata;
            default:   return forwardmux2::idex_rs2;
        endcase
    endfunction

    forwardmux1::forwardmux1_sel_t         fwd1_q;
    forwardmux2::forwardmux2_sel_t         fwd2_q;
    mem_forwardmux2::mem_forwardmux2_sel_t memfwd2_q;
    logic                                  st_hit;

    // Store data of the instruction entering MEM comes from the one entering WB
    assign st_hit = bus.exmem_regwrite && (bus.exmem_rd != REG_X0) && (bus.exmem_rd == bus.idex_rs2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd1_q    <= forwardmux1::idex_rs1;
            fwd2_q    <= forwardmux2::idex_rs2;
            memfwd2_q <= mem_forwardmux2::exmem_rs2;
        end else begin
            if (idex_ld) begin
                fwd1_q <= idex_fl ? forwardmux1::idex_rs1 : to_fwd1(src_n[0]);
                fwd2_q <= idex_fl ? forwardmux2::idex_rs2 : to_fwd2(src_n[1]);
            end
            if (exmem_ld)
                memfwd2_q <= st_hit ? mem_forwardmux2::regfilemux : mem_forwardmux2::exmem_rs2;
        end
    end

    assign bus.fwd1_sel    = fwd1_q;
    assign bus.fwd2_sel    = fwd2_q;
    assign bus.memfwd2_sel = memfwd2_q;

    // [0] stall cycles, [1] load-use bubbles, [2] branch flushes
    logic [2:0]            cnt_ev;
    logic [2:0][CNT_W-1:0] cnt_q;

    assign cnt_ev = {flush_ev, bubble_ev, mem_busy};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (bus.cnt_clr)
                    cnt_q[i] <= '0;
                else if (cnt_ev[i] && cnt_q[i] != '1)
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
        end
    end

    assign bus.cnt_stall  = cnt_q[0];
    assign bus.cnt_bubble = cnt_q[1];
    assign bus.cnt_flush  = cnt_q[2];
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench: two instances (bubble and mem_rdata-forward variants) share one stimulus stream.
module tb_hazard_fwd_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_fwd_unit_if #(.CNT_W(32)) bus_a ();
    hazard_fwd_unit_if #(.CNT_W(4))  bus_b ();

    hazard_fwd_unit #(.LOAD_USE_BUBBLE(1'b1), .CNT_W(32)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    hazard_fwd_unit #(.LOAD_USE_BUBBLE(1'b0), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    typedef struct packed {
        logic       rst, icr, icp, dcr, dcp;
        logic [4:0] rs1, rs2, ex_rs2, ex_rd;
        logic       ex_rw, ex_ld;
        logic [4:0] mem_rd;
        logic       mem_rw, br, clr;
    } stim_t;

    typedef struct {
        forwardmux1::forwardmux1_sel_t         f1;
        forwardmux2::forwardmux2_sel_t         f2;
        mem_forwardmux2::mem_forwardmux2_sel_t m2;
        longint                                c [3];
    } mst_t;

    typedef struct {
        logic [6:0] strb [2];
        mst_t       st   [2];
    } exp_t;

    exp_t exp_q [$];
    mst_t cur [2];
    mst_t nxt [2];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic mst_t def_state();
        mst_t m;
        m.f1 = forwardmux1::idex_rs1;
        m.f2 = forwardmux2::idex_rs2;
        m.m2 = mem_forwardmux2::exmem_rs2;
        m.c  = '{0, 0, 0};
        return m;
    endfunction

    // 0: register file, 1: EX result, 2: load data, 3: WB value
    function automatic int producer(input logic [4:0] rs, input stim_t s, input bit lub);
        if (rs == 5'd0) return 0;
        if (s.ex_rw && s.ex_rd == rs) return (s.ex_ld && !lub) ? 2 : 1;
        if (s.mem_rw && s.mem_rd == rs) return 3;
        return 0;
    endfunction

    function automatic void model(input stim_t s, input int d, input mst_t st,
                                  output logic [6:0] strb, output mst_t nx);
        bit     lub  = (d == 0);
        longint cmax = (d == 0) ? 64'hFFFF_FFFF : 64'd15;
        bit     busy, lu;
        int     act, p1, p2;
        nx = st;
        strb = 7'b0;
        if (!s.rst) begin
            nx = def_state();
            return;
        end
        busy = (s.icr && !s.icp) || (s.dcr && !s.dcp);
        lu   = lub && s.ex_ld && s.ex_rw && s.ex_rd != 0 && (s.ex_rd == s.rs1 || s.ex_rd == s.rs2);
        act  = busy ? 0 : s.br ? 1 : lu ? 2 : 3;
        case (act)
            0: strb = 7'b00000_00;
            1: strb = 7'b11111_11;
            2: strb = 7'b00111_01;
            default: strb = 7'b11111_00;
        endcase
        if (act != 0) begin
            p1 = producer(s.rs1, s, lub);
            p2 = producer(s.rs2, s, lub);
            case (p1)
                1: nx.f1 = forwardmux1::exmem_alu;
                2: nx.f1 = forwardmux1::mem_rdata;
                3: nx.f1 = forwardmux1::regfilemux;
                default: nx.f1 = forwardmux1::idex_rs1;
            endcase
            case (p2)
                1: nx.f2 = forwardmux2::exmem_alu;
                2: nx.f2 = forwardmux2::mem_rdata;
                3: nx.f2 = forwardmux2::regfilemux;
                default: nx.f2 = forwardmux2::idex_rs2;
            endcase
            if (act != 3) begin
                nx.f1 = forwardmux1::idex_rs1;
                nx.f2 = forwardmux2::idex_rs2;
            end
            nx.m2 = (s.mem_rw && s.mem_rd != 0 && s.mem_rd == s.ex_rs2) ?
                    mem_forwardmux2::regfilemux : mem_forwardmux2::exmem_rs2;
        end
        for (int k = 0; k < 3; k++) begin
            bit ev = (k == 0) ? busy : (k == 1) ? (act == 2) : (act == 1);
            if (s.clr) nx.c[k] = 0;
            else if (ev && nx.c[k] < cmax) nx.c[k] = nx.c[k] + 1;
        end
    endfunction

    task automatic apply(input stim_t s);
        rst = s.rst;
        bus_a.icache_req = s.icr;  bus_b.icache_req = s.icr;
        bus_a.icache_resp = s.icp; bus_b.icache_resp = s.icp;
        bus_a.dcache_req = s.dcr;  bus_b.dcache_req = s.dcr;
        bus_a.dcache_resp = s.dcp; bus_b.dcache_resp = s.dcp;
        bus_a.ifid_rs1 = s.rs1;    bus_b.ifid_rs1 = s.rs1;
        bus_a.ifid_rs2 = s.rs2;    bus_b.ifid_rs2 = s.rs2;
        bus_a.idex_rs2 = s.ex_rs2; bus_b.idex_rs2 = s.ex_rs2;
        bus_a.idex_rd = s.ex_rd;   bus_b.idex_rd = s.ex_rd;
        bus_a.idex_regwrite = s.ex_rw; bus_b.idex_regwrite = s.ex_rw;
        bus_a.idex_is_load = s.ex_ld;  bus_b.idex_is_load = s.ex_ld;
        bus_a.exmem_rd = s.mem_rd;     bus_b.exmem_rd = s.mem_rd;
        bus_a.exmem_regwrite = s.mem_rw; bus_b.exmem_regwrite = s.mem_rw;
        bus_a.br_taken = s.br;     bus_b.br_taken = s.br;
        bus_a.cnt_clr = s.clr;     bus_b.cnt_clr = s.clr;
    endtask

    // One cycle: commit model state for the edge just taken, drive, predict, enqueue
    task automatic drive(input stim_t s);
        exp_t e;
        mst_t nx;
        logic [6:0] strb;
        @(posedge clk);
        cur = nxt;
        #1;
        apply(s);
        for (int d = 0; d < 2; d++) begin
            model(s, d, cur[d], strb, nx);
            e.strb[d] = strb;
            e.st[d]   = s.rst ? cur[d] : nx;
            nxt[d]    = nx;
        end
        exp_q.push_back(e);
    endtask

    function automatic stim_t idle();
        stim_t s = '0;
        s.rst = 1'b1;
        return s;
    endfunction

    function automatic logic [4:0] rnd_idx();
        return ($urandom_range(0, 5) == 5) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.rst    = ($urandom_range(0, 499) != 0);
        s.icr    = ($urandom_range(0, 9) < 1);
        s.icp    = 1'($urandom_range(0, 1));
        s.dcr    = ($urandom_range(0, 9) < 2);
        s.dcp    = 1'($urandom_range(0, 1));
        s.rs1    = rnd_idx();
        s.rs2    = rnd_idx();
        s.ex_rs2 = rnd_idx();
        s.ex_rd  = rnd_idx();
        s.ex_rw  = ($urandom_range(0, 9) < 7);
        s.ex_ld  = ($urandom_range(0, 9) < 4);
        s.mem_rd = rnd_idx();
        s.mem_rw = ($urandom_range(0, 9) < 7);
        s.br     = ($urandom_range(0, 99) < 12);
        s.clr    = ($urandom_range(0, 199) == 0);
        return s;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Monitor: every negedge the DUTs present a full response; compare against the oldest prediction
    initial begin
        exp_t me;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                me = exp_q.pop_front();
                chk("A strobes", {bus_a.pc_load, bus_a.ifid_load, bus_a.idex_load, bus_a.exmem_load,
                                  bus_a.memwb_load, bus_a.ifid_flush, bus_a.idex_flush}, 64'(me.strb[0]));
                chk("A fwd1_sel", 64'(bus_a.fwd1_sel), 64'(me.st[0].f1));
                chk("A fwd2_sel", 64'(bus_a.fwd2_sel), 64'(me.st[0].f2));
                chk("A memfwd2_sel", 64'(bus_a.memfwd2_sel), 64'(me.st[0].m2));
                chk("A cnt_stall", 64'(bus_a.cnt_stall), me.st[0].c[0]);
                chk("A cnt_bubble", 64'(bus_a.cnt_bubble), me.st[0].c[1]);
                chk("A cnt_flush", 64'(bus_a.cnt_flush), me.st[0].c[2]);
                chk("B strobes", {bus_b.pc_load, bus_b.ifid_load, bus_b.idex_load, bus_b.exmem_load,
                                  bus_b.memwb_load, bus_b.ifid_flush, bus_b.idex_flush}, 64'(me.strb[1]));
                chk("B fwd1_sel", 64'(bus_b.fwd1_sel), 64'(me.st[1].f1));
                chk("B fwd2_sel", 64'(bus_b.fwd2_sel), 64'(me.st[1].f2));
                chk("B memfwd2_sel", 64'(bus_b.memfwd2_sel), 64'(me.st[1].m2));
                chk("B cnt_stall", 64'(bus_b.cnt_stall), me.st[1].c[0]);
                chk("B cnt_bubble", 64'(bus_b.cnt_bubble), me.st[1].c[1]);
                chk("B cnt_flush", 64'(bus_b.cnt_flush), me.st[1].c[2]);
            end
        end
    end

    initial begin
        stim_t s;
        s = idle();
        s.rst = 1'b0;
        apply(s);
        nxt[0] = def_state();
        nxt[1] = def_state();
        drive(s);
        drive(s);

        // add x1,x2,x3 ; add x4,x1,x1
        s = idle(); s.ex_rd = 5'd1; s.ex_rw = 1'b1; s.rs1 = 5'd1; s.rs2 = 5'd1;
        drive(s);
        drive(idle());
        // lw x5,0(x0) ; add x6,x5,x0 then the bubble/load moves on
        s = idle(); s.ex_rd = 5'd5; s.ex_rw = 1'b1; s.ex_ld = 1'b1; s.rs1 = 5'd5;
        drive(s);
        s = idle(); s.mem_rd = 5'd5; s.mem_rw = 1'b1; s.rs1 = 5'd5;
        drive(s);
        drive(idle());
        // addi x0,x0,5 ; add x7,x0,x0
        s = idle(); s.ex_rd = 5'd0; s.ex_rw = 1'b1;
        drive(s);
        drive(idle());
        // five dcache wait cycles then response, with a live forward pending
        s = idle(); s.dcr = 1'b1; s.ex_rd = 5'd2; s.ex_rw = 1'b1; s.rs1 = 5'd2;
        repeat (5) drive(s);
        s.dcp = 1'b1;
        drive(s);
        // branch over a load-use hazard, then branch held through an icache wait
        s = idle(); s.br = 1'b1; s.ex_rd = 5'd5; s.ex_rw = 1'b1; s.ex_ld = 1'b1; s.rs2 = 5'd5;
        drive(s);
        s.icr = 1'b1;
        repeat (2) drive(s);
        s.icp = 1'b1;
        drive(s);
        // build non-default selects and counters, then reset in the middle of a stall
        s = idle(); s.ex_rd = 5'd3; s.ex_rw = 1'b1; s.rs1 = 5'd3; s.rs2 = 5'd3;
        s.mem_rd = 5'd1; s.mem_rw = 1'b1; s.ex_rs2 = 5'd1;
        drive(s);
        s = idle(); s.dcr = 1'b1;
        repeat (7) drive(s);
        s.rst = 1'b0;
        drive(s);
        s = idle(); s.br = 1'b1; s.clr = 1'b1;
        drive(s);
        drive(idle());

        repeat (3000) drive(rnd());

        repeat (2) @(negedge clk);
        chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
